// File: rtl/pixel_fetch_if.sv
// Bus bundle between pixel_fetch, the framebuffer RAM and the scan stage.
// slave  = pixel_fetch side, master = scan stage / RAM / bench side.
interface pixel_fetch_if #(
    parameter int COLOR_DEPTH  = 6,
    parameter int COLUMN_WIDTH = 6,
    parameter int ROW_WIDTH    = 4
);
    localparam int AW = ROW_WIDTH + COLUMN_WIDTH + 2;

    logic                     pixel_load;
    logic [COLUMN_WIDTH-1:0]  column_address;
    logic [ROW_WIDTH-1:0]     row_address;
    logic [COLOR_DEPTH-1:0]   brightness_mask;
    logic [AW-1:0]            ram_addr;
    logic                     ram_rd_en;
    logic [3*COLOR_DEPTH-1:0] ram_rd_data;
    logic [2:0]               rgb_top;
    logic [2:0]               rgb_bottom;
    logic                     pixel_valid;
    logic                     busy;
    logic                     overrun;
    logic                     frame_swap_req;
    logic                     frame_swap_ack;
    logic                     frame_sel;

    modport slave (
        input  pixel_load, column_address, row_address, brightness_mask,
               ram_rd_data, frame_swap_req,
        output ram_addr, ram_rd_en, rgb_top, rgb_bottom, pixel_valid,
               busy, overrun, frame_swap_ack, frame_sel
    );

    modport master (
        output pixel_load, column_address, row_address, brightness_mask,
               ram_rd_data, frame_swap_req,
        input  ram_addr, ram_rd_en, rgb_top, rgb_bottom, pixel_valid,
               busy, overrun, frame_swap_ack, frame_sel
    );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch: per pixel-load strobe, reads the top-half and bottom-half
// framebuffer words, picks the bit-plane named by brightness_mask and
// presents registered RGB bits for both halves.
// Optional: PIXEL_FETCH_DOUBLE_BUFFER_EN adds framebuffer swapping at the
// first pixel of a frame (row 0, last column, MSB bit-plane).
module pixel_fetch #(
    parameter int COLOR_DEPTH  = 6,
    parameter int COLUMN_WIDTH = 6,
    parameter int ROW_WIDTH    = 4
) (
    input  logic         clk_in,
    input  logic         reset,
    pixel_fetch_if.slave bus
);
    localparam int AW = ROW_WIDTH + COLUMN_WIDTH + 2;
    localparam logic [COLOR_DEPTH-1:0] MASK_MSB = {1'b1, {(COLOR_DEPTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RD_TOP, RD_BOT, WAIT_BOT} state_t;

    state_t                  state_q, state_d;
    logic [COLUMN_WIDTH-1:0] col_q, col_d;
    logic [ROW_WIDTH-1:0]    row_q, row_d;
    logic [COLOR_DEPTH-1:0]  mask_q, mask_d;
    logic [AW-1:0]           ram_addr_q, ram_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic [2:0]              top_bits_q, top_bits_d;
    logic [2:0]              rgb_top_q, rgb_top_d;
    logic [2:0]              rgb_bot_q, rgb_bot_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    cur_frame;   // frame of the fetch in flight
    logic                    next_frame;  // frame used by a fetch starting now

    // Reduce one {R,G,B} word to one bit per channel for the chosen plane(s).
    function automatic logic [2:0] plane_bits(input logic [3*COLOR_DEPTH-1:0] word,
                                              input logic [COLOR_DEPTH-1:0]   mask);
        plane_bits = {|(word[3*COLOR_DEPTH-1:2*COLOR_DEPTH] & mask),
                      |(word[2*COLOR_DEPTH-1:COLOR_DEPTH]   & mask),
                      |(word[COLOR_DEPTH-1:0]               & mask)};
    endfunction

`ifdef PIXEL_FETCH_DOUBLE_BUFFER_EN
    logic frame_sel_q, frame_sel_d;
    logic ack_q, ack_d;
    logic pending_q, pending_d;
    logic swap;

    // Swap on the accepted strobe that starts a frame while a request is pending;
    // a request arriving on the swap edge itself stays pending for the next frame.
    always_comb begin
        swap        = bus.pixel_load && (state_q == IDLE) && pending_q &&
                      (bus.row_address == '0) && (bus.column_address == '1) &&
                      (bus.brightness_mask == MASK_MSB);
        frame_sel_d = frame_sel_q ^ swap;
        ack_d       = swap;
        pending_d   = (pending_q && !swap) || bus.frame_swap_req;
    end

    // Double-buffer state registers.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            frame_sel_q <= 1'b0;
            ack_q       <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            frame_sel_q <= frame_sel_d;
            ack_q       <= ack_d;
            pending_q   <= pending_d;
        end
    end

    assign cur_frame          = frame_sel_q;
    assign next_frame         = frame_sel_d;
    assign bus.frame_sel      = frame_sel_q;
    assign bus.frame_swap_ack = ack_q;
`else
    logic unused_swap_req;
    assign unused_swap_req    = bus.frame_swap_req;
    assign cur_frame          = 1'b0;
    assign next_frame         = 1'b0;
    assign bus.frame_sel      = 1'b0;
    assign bus.frame_swap_ack = 1'b0;
`endif

    // Fetch sequencer: issue top and bottom reads back to back, then fold
    // each returned word into RGB bits as it arrives one cycle later.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        mask_d     = mask_q;
        ram_addr_d = ram_addr_q;
        rd_en_d    = 1'b0;
        top_bits_d = top_bits_q;
        rgb_top_d  = rgb_top_q;
        rgb_bot_d  = rgb_bot_q;
        valid_d    = 1'b0;
        // A strobe arriving mid-fetch is dropped and remembered until reset.
        overrun_d  = overrun_q || (bus.pixel_load && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (bus.pixel_load) begin
                    col_d      = bus.column_address;
                    row_d      = bus.row_address;
                    mask_d     = bus.brightness_mask;
                    ram_addr_d = {next_frame, 1'b0, bus.row_address, bus.column_address};
                    rd_en_d    = 1'b1;
                    state_d    = RD_TOP;
                end
            end
            RD_TOP: begin
                ram_addr_d = {cur_frame, 1'b1, row_q, col_q};
                rd_en_d    = 1'b1;
                state_d    = RD_BOT;
            end
            RD_BOT: begin
                top_bits_d = plane_bits(bus.ram_rd_data, mask_q);
                state_d    = WAIT_BOT;
            end
            WAIT_BOT: begin
                rgb_top_d = top_bits_q;
                rgb_bot_d = plane_bits(bus.ram_rd_data, mask_q);
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and output registers; reset abandons any fetch in flight.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            mask_q     <= '0;
            ram_addr_q <= '0;
            rd_en_q    <= 1'b0;
            top_bits_q <= '0;
            rgb_top_q  <= '0;
            rgb_bot_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            mask_q     <= mask_d;
            ram_addr_q <= ram_addr_d;
            rd_en_q    <= rd_en_d;
            top_bits_q <= top_bits_d;
            rgb_top_q  <= rgb_top_d;
            rgb_bot_q  <= rgb_bot_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_rd_en   = rd_en_q;
    assign bus.rgb_top     = rgb_top_q;
    assign bus.rgb_bottom  = rgb_bot_q;
    assign bus.pixel_valid = valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: RAM model with 1-cycle registered
// read, expected RGB results queued at strobe time and popped at pixel_valid.
module tb_pixel_fetch;
    localparam int CD = 6;
    localparam int CW = 6;
    localparam int RW = 4;
    localparam int AW = RW + CW + 2;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;

    pixel_fetch_if #(.COLOR_DEPTH(CD), .COLUMN_WIDTH(CW), .ROW_WIDTH(RW)) bus ();

    pixel_fetch #(.COLOR_DEPTH(CD), .COLUMN_WIDTH(CW), .ROW_WIDTH(RW)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Framebuffer RAM model.
    logic [3*CD-1:0] mem [0:(1<<AW)-1];
    logic [3*CD-1:0] ram_q = '0;
    always @(posedge clk_in) if (bus.ram_rd_en) ram_q <= mem[bus.ram_addr];
    assign bus.ram_rd_data = ram_q;

    // Count swap acknowledges seen.
    int ack_cnt = 0;
    always @(posedge clk_in) if (bus.frame_swap_ack === 1'b1) ack_cnt <= ack_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] sb_q [$];   // {rgb_top, rgb_bottom}

    function automatic logic [2:0] exp_bits(input logic [3*CD-1:0] w, input logic [CD-1:0] m);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < CD; i++)
            if (m[i]) begin
                r[2] = r[2] | w[2*CD+i];
                r[1] = r[1] | w[CD+i];
                r[0] = r[0] | w[i];
            end
        return r;
    endfunction

    // One complete fetch with address, latency, pulse-width and result checks.
    task automatic do_fetch(input logic [CW-1:0] col, input logic [RW-1:0] row,
                            input logic [CD-1:0] mask, input logic fs);
        logic [AW-1:0] a_top, a_bot;
        logic [5:0] e;
        int lat;
        a_top = {fs, 1'b0, row, col};
        a_bot = {fs, 1'b1, row, col};
        @(posedge clk_in); #1;
        bus.pixel_load = 1'b1; bus.column_address = col;
        bus.row_address = row; bus.brightness_mask = mask;
        sb_q.push_back({exp_bits(mem[a_top], mask), exp_bits(mem[a_bot], mask)});
        @(posedge clk_in); #1;                       // E0
        bus.pixel_load = 1'b0;
        n_cmp++;
        if (bus.ram_addr !== a_top || bus.ram_rd_en !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL addr_top: got addr=%h en=%b busy=%b want addr=%h en=1 busy=1",
                     bus.ram_addr, bus.ram_rd_en, bus.busy, a_top);
        end
        @(posedge clk_in); #1;                       // E1
        n_cmp++;
        if (bus.ram_addr !== a_bot || bus.ram_rd_en !== 1'b1) begin
            n_err++;
            $display("FAIL addr_bot: got addr=%h en=%b want addr=%h en=1",
                     bus.ram_addr, bus.ram_rd_en, a_bot);
        end
        lat = 0;
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk_in); #1;
            if (bus.pixel_valid === 1'b1) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != 3) begin
            n_err++;
            $display("FAIL latency: got %0d edges want 3", lat);
        end
        if (lat != 0) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 6'bx;
            n_cmp++;
            if ({bus.rgb_top, bus.rgb_bottom} !== e) begin
                n_err++;
                $display("FAIL rgb mask=%b: got top=%b bot=%b want top=%b bot=%b",
                         mask, bus.rgb_top, bus.rgb_bottom, e[5:3], e[2:0]);
            end
            @(posedge clk_in); #1;
            n_cmp++;
            if (bus.pixel_valid !== 1'b0 || {bus.rgb_top, bus.rgb_bottom} !== e || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL valid_pulse: got valid=%b busy=%b rgb=%b want valid=0 busy=0 rgb=%b",
                         bus.pixel_valid, bus.busy, {bus.rgb_top, bus.rgb_bottom}, e);
            end
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_in); #1;
            n_cmp++;
            if (bus.ram_addr !== '0 || bus.ram_rd_en !== 1'b0 || bus.rgb_top !== 3'b000 ||
                bus.rgb_bottom !== 3'b000 || bus.pixel_valid !== 1'b0 || bus.busy !== 1'b0 ||
                bus.overrun !== 1'b0 || bus.frame_sel !== 1'b0 || bus.frame_swap_ack !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: got addr=%h en=%b top=%b bot=%b valid=%b busy=%b ovr=%b fs=%b ack=%b want all 0",
                         bus.ram_addr, bus.ram_rd_en, bus.rgb_top, bus.rgb_bottom, bus.pixel_valid,
                         bus.busy, bus.overrun, bus.frame_sel, bus.frame_swap_ack);
            end
        end
    endtask

    task automatic test_single_fetch();
        mem[{1'b0, 1'b0, 4'd5, 6'd63}] = {6'h3F, 6'h00, 6'h20};
        mem[{1'b0, 1'b1, 4'd5, 6'd63}] = {6'h00, 6'h21, 6'h00};
        do_fetch(6'd63, 4'd5, 6'b100000, 1'b0);
        n_cmp++;
        if (bus.rgb_top !== 3'b101 || bus.rgb_bottom !== 3'b010) begin
            n_err++;
            $display("FAIL single_fixed: got top=%b bot=%b want top=101 bot=010",
                     bus.rgb_top, bus.rgb_bottom);
        end
    endtask

    task automatic test_bit_planes();
        logic [CD-1:0] m;
        mem[{1'b0, 1'b0, 4'd7, 6'd12}] = {6'h2A, 6'h15, 6'h33};
        mem[{1'b0, 1'b1, 4'd7, 6'd12}] = {6'h0F, 6'h30, 6'h3C};
        for (int i = 0; i < CD; i++) begin
            m = '0; m[i] = 1'b1;
            do_fetch(6'd12, 4'd7, m, 1'b0);
        end
        do_fetch(6'd12, 4'd7, 6'b000000, 1'b0);
        n_cmp++;
        if (bus.rgb_top !== 3'b000 || bus.rgb_bottom !== 3'b000) begin
            n_err++;
            $display("FAIL mask_zero: got top=%b bot=%b want 000/000", bus.rgb_top, bus.rgb_bottom);
        end
        do_fetch(6'd12, 4'd7, 6'b010010, 1'b0);   // non-one-hot: OR of planes
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_fetch(CW'($urandom_range(0, 63)), RW'($urandom_range(1, 15)),
                     CD'($urandom_range(0, 63)), 1'b0);
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_idle: got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_overrun();
        logic [5:0] e, got;
        int nvalid;
        mem[{1'b0, 1'b0, 4'd3, 6'd10}] = {6'h04, 6'h00, 6'h3B};
        mem[{1'b0, 1'b1, 4'd3, 6'd10}] = {6'h00, 6'h04, 6'h04};
        @(posedge clk_in); #1;
        bus.pixel_load = 1'b1; bus.column_address = 6'd10;
        bus.row_address = 4'd3; bus.brightness_mask = 6'b000100;
        sb_q.push_back({3'b100, 3'b011});
        @(posedge clk_in); #1;                       // E0
        bus.pixel_load = 1'b0;
        @(posedge clk_in); #1;                       // E1
        bus.pixel_load = 1'b1; bus.column_address = 6'd20;
        bus.row_address = 4'd9; bus.brightness_mask = 6'b111111;
        @(posedge clk_in); #1;                       // E2, strobe dropped
        bus.pixel_load = 1'b0;
        nvalid = 0; got = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_in); #1;
            if (bus.pixel_valid === 1'b1) begin
                if (nvalid == 0) got = {bus.rgb_top, bus.rgb_bottom};
                nvalid++;
            end
        end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 6'bx;
        n_cmp++;
        if (nvalid != 1) begin
            n_err++;
            $display("FAIL overrun_valids: got %0d want 1", nvalid);
        end
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL overrun_rgb: got %b want %b", got, e);
        end
        n_cmp++;
        if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_flag: got ovr=%b busy=%b want ovr=1 busy=0", bus.overrun, bus.busy);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int nvalid;
        @(posedge clk_in); #1;
        bus.pixel_load = 1'b1; bus.column_address = 6'd1;
        bus.row_address = 4'd2; bus.brightness_mask = 6'b111111;
        @(posedge clk_in); #1;                       // E0
        bus.pixel_load = 1'b0;
        @(posedge clk_in); #1;                       // E1, now in RD_BOT
        reset = 1'b0;
        @(posedge clk_in); #1;
        reset = 1'b1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.pixel_valid !== 1'b0 || bus.rgb_top !== 3'b000 ||
            bus.rgb_bottom !== 3'b000 || bus.overrun !== 1'b0 || bus.ram_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b valid=%b top=%b bot=%b ovr=%b en=%b want all 0",
                     bus.busy, bus.pixel_valid, bus.rgb_top, bus.rgb_bottom, bus.overrun, bus.ram_rd_en);
        end
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_in); #1;
            if (bus.pixel_valid === 1'b1) nvalid++;
        end
        n_cmp++;
        if (nvalid != 0) begin
            n_err++;
            $display("FAIL reset_mid_valid: got %0d pulses want 0", nvalid);
        end
    endtask

    task automatic test_frame_swap();
        int ack0;
        ack0 = ack_cnt;
        @(posedge clk_in); #1 bus.frame_swap_req = 1'b1;
        @(posedge clk_in); #1 bus.frame_swap_req = 1'b0;
        do_fetch(6'd5, 4'd0, 6'b100000, 1'b0);      // not a frame start
        n_cmp++;
        if (ack_cnt != ack0 || bus.frame_sel !== 1'b0) begin
            n_err++;
            $display("FAIL no_swap_midframe: got acks=%0d fs=%b want acks=%0d fs=0",
                     ack_cnt - ack0, bus.frame_sel, 0);
        end
`ifdef PIXEL_FETCH_DOUBLE_BUFFER_EN
        do_fetch(6'd63, 4'd0, 6'b100000, 1'b1);     // frame start: swap
        n_cmp++;
        if (ack_cnt != ack0 + 1 || bus.frame_sel !== 1'b1) begin
            n_err++;
            $display("FAIL swap: got acks=%0d fs=%b want acks=1 fs=1", ack_cnt - ack0, bus.frame_sel);
        end
        do_fetch(6'd63, 4'd0, 6'b100000, 1'b1);     // frame start, nothing pending
        n_cmp++;
        if (ack_cnt != ack0 + 1 || bus.frame_sel !== 1'b1) begin
            n_err++;
            $display("FAIL swap_once: got acks=%0d fs=%b want acks=1 fs=1", ack_cnt - ack0, bus.frame_sel);
        end
`else
        do_fetch(6'd63, 4'd0, 6'b100000, 1'b0);     // feature off: never swaps
        n_cmp++;
        if (ack_cnt != ack0 || bus.frame_sel !== 1'b0) begin
            n_err++;
            $display("FAIL swap_disabled: got acks=%0d fs=%b want acks=0 fs=0", ack_cnt - ack0, bus.frame_sel);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = (3*CD)'($urandom);
        bus.pixel_load      = 1'b0;
        bus.column_address  = '0;
        bus.row_address     = '0;
        bus.brightness_mask = '0;
        bus.frame_swap_req  = 1'b0;
        test_reset();
        test_single_fetch();
        test_bit_planes();
        test_back_to_back();
        test_overrun();
        test_reset_mid_fetch();
        test_frame_swap();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
